// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle unsigned subtractor, difference = a - b.
// Processes DIGIT bits per clock, LSB digit first. A registered borrow
// carries between digits. Operands are accepted through a start/done
// handshake. WIDTH must be a multiple of DIGIT.
// Optional build macro: SERIAL_SUB_SAT_EN. When it is defined, a result
// with a final borrow saturates to zero. Without it, the result wraps.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject configurations that cannot be split into whole digits.
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]  b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]  acc_reg, acc_next;
    logic              borrow_int_reg, borrow_int_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  difference_reg, difference_next;
    logic              borrow_reg, borrow_next;
    logic              zero_reg, zero_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    // Per-digit arithmetic results, shared by the RUN branch.
    logic [DIGIT:0]    borrow_in_ext;
    logic [DIGIT:0]    digit_full;
    logic [WIDTH-1:0]  acc_shifted;
    logic [WIDTH-1:0]  final_value;

    // Next-state, datapath and output logic.
    always_comb begin
        state_next      = state_reg;
        a_sh_next       = a_sh_reg;
        b_sh_next       = b_sh_reg;
        acc_next        = acc_reg;
        borrow_int_next = borrow_int_reg;
        cnt_next        = cnt_reg;
        difference_next = difference_reg;
        borrow_next     = borrow_reg;
        zero_next       = zero_reg;

        // Subtract one digit in DIGIT+1 bits. The top bit is the borrow out,
        // because the result goes negative exactly when a borrow is needed.
        borrow_in_ext = {{DIGIT{1'b0}}, borrow_int_reg};
        digit_full    = {1'b0, a_sh_reg[DIGIT-1:0]}
                      - {1'b0, b_sh_reg[DIGIT-1:0]}
                      - borrow_in_ext;

        // The new digit enters at the MSB end. After N digits, the first
        // digit has reached bit 0.
        acc_shifted = (acc_reg >> DIGIT)
                    | (WIDTH'(digit_full[DIGIT-1:0]) << (WIDTH - DIGIT));

`ifdef SERIAL_SUB_SAT_EN
        final_value = digit_full[DIGIT] ? '0 : acc_shifted;
`else
        final_value = acc_shifted;
`endif

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_next       = a;
                    b_sh_next       = b;
                    acc_next        = '0;
                    borrow_int_next = 1'b0;
                    cnt_next        = '0;
                    state_next      = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                a_sh_next       = a_sh_reg >> DIGIT;
                b_sh_next       = b_sh_reg >> DIGIT;
                acc_next        = acc_shifted;
                borrow_int_next = digit_full[DIGIT];
                cnt_next        = cnt_reg + 1'b1;
                if (cnt_reg == CW'(N - 1)) begin
                    difference_next = final_value;
                    borrow_next     = digit_full[DIGIT];
                    zero_next       = (final_value == '0);
                    state_next      = DONE;
                end
            end
            default: state_next = IDLE;
        endcase

        // busy and done are registered copies of the next state decode,
        // so no input reaches an output without passing through a flop.
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            acc_reg        <= '0;
            borrow_int_reg <= 1'b0;
            cnt_reg        <= '0;
            difference_reg <= '0;
            borrow_reg     <= 1'b0;
            zero_reg       <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_sh_reg       <= a_sh_next;
            b_sh_reg       <= b_sh_next;
            acc_reg        <= acc_next;
            borrow_int_reg <= borrow_int_next;
            cnt_reg        <= cnt_next;
            difference_reg <= difference_next;
            borrow_reg     <= borrow_next;
            zero_reg       <= zero_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign difference = difference_reg;
    assign borrow     = borrow_reg;
    assign zero       = zero_reg;

endmodule
